// File: rtl/fm_pac_multi.sv
// Multi-channel FM-PAC cartridge mapper: per-channel enable/bank/SRAM-unlock registers
// plus per-channel OPLL write FIFOs drained by a round-robin arbiter with write pacing.
module fm_pac_multi #(
    parameter int SLOTS      = 2,
    parameter int BANK_BITS  = 2,
    parameter int SRAM_AW    = 13,
    parameter int FIFO_DEPTH = 4,
    parameter int WAIT_ADDR  = 12,
    parameter int WAIT_DATA  = 84
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      addr,
    input  logic [7:0]       d_from_cpu,
    output logic [7:0]       mapper_dout,
    input  logic [SLOTS-1:0] cs,
    input  logic             wr,
    input  logic             rd,
    input  logic             mreq,
    output logic             sram_cs,
    output logic             sram_we,
    output logic             mem_unmaped,
    output logic [24:0]      mem_addr,
    output logic             opll_wr,
    output logic [1:0]       opll_ch,
    output logic             opll_a0,
    output logic [7:0]       opll_dout,
    output logic [SLOTS-1:0] opll_io_enable
);

    localparam int FAW   = $clog2(FIFO_DEPTH);
    localparam int MAXW  = (WAIT_DATA > WAIT_ADDR) ? WAIT_DATA : WAIT_ADDR;
    localparam int CNT_W = $clog2(MAXW + 1);

    localparam logic [FAW-1:0]   PTR_ONE   = FAW'(1);
    localparam logic [FAW:0]     CNT_ONE   = (FAW + 1)'(1);
    localparam logic [FAW:0]     CNT_FULL  = (FAW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WAIT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WAIT_A    = CNT_W'(WAIT_ADDR);
    localparam logic [CNT_W-1:0] WAIT_D    = CNT_W'(WAIT_DATA);
    localparam logic [2:0]       SLOTS_3   = 3'(SLOTS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    logic [13:0]          offset;
    logic                 isOpllPort;
    logic [SLOTS-1:0]     wrLevel;
    logic [SLOTS-1:0]     wrLevel_q;
    logic [SLOTS-1:0]     wrEvent;

    logic [7:0]           enable_q  [SLOTS];
    logic [BANK_BITS-1:0] bank_q    [SLOTS];
    logic [7:0]           magicLo_q [SLOTS];
    logic [7:0]           magicHi_q [SLOTS];
    logic [SLOTS-1:0]     overflow_q;
    logic [SLOTS-1:0]     sramEnable;

    logic [8:0]           fifoMem_q [SLOTS][FIFO_DEPTH];
    logic [FAW-1:0]       rdPtr_q   [SLOTS];
    logic [FAW-1:0]       wrPtr_q   [SLOTS];
    logic [FAW:0]         count_q   [SLOTS];
    logic [SLOTS-1:0]     notEmpty;
    logic [SLOTS-1:0]     full;
    logic [SLOTS-1:0]     push;
    logic [SLOTS-1:0]     pop;
    logic [SLOTS-1:0]     overflowSet;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           arbPtr_q, arbPtr_d;
    logic                 opllWr_q, opllWr_d;
    logic [1:0]           opllCh_q, opllCh_d;
    logic                 opllA0_q, opllA0_d;
    logic [7:0]           opllDout_q, opllDout_d;

    logic                 found;
    logic [1:0]           winner;
    logic [8:0]           headData;
    logic                 popValid;
    logic [3:0]           notEmptyPad;
    logic [2:0]           scanIdx;
    logic [2:0]           nextIdx;

    assign offset     = addr[13:0];
    assign isOpllPort = (offset[13:1] == 13'h1FFA);
    assign wrLevel    = cs & {SLOTS{wr & mreq}};
    assign wrEvent    = wrLevel & ~wrLevel_q;

    always_comb begin
        notEmpty    = '0;
        full        = '0;
        sramEnable  = '0;
        push        = '0;
        overflowSet = '0;
        for (int i = 0; i < SLOTS; i++) begin
            notEmpty[i]   = (count_q[i] != '0);
            full[i]       = (count_q[i] == CNT_FULL);
            sramEnable[i] = ({magicHi_q[i], magicLo_q[i]} == 16'h694D);
            // A pop in the same cycle frees a slot, so a full FIFO can still accept.
            push[i]        = wrEvent[i] & isOpllPort & (~full[i] | pop[i]);
            overflowSet[i] = wrEvent[i] & isOpllPort & full[i] & ~pop[i];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrLevel_q  <= '0;
            overflow_q <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                enable_q[i]  <= '0;
                bank_q[i]    <= '0;
                magicLo_q[i] <= '0;
                magicHi_q[i] <= '0;
                rdPtr_q[i]   <= '0;
                wrPtr_q[i]   <= '0;
                count_q[i]   <= '0;
            end
        end else begin
            wrLevel_q <= wrLevel;
            for (int i = 0; i < SLOTS; i++) begin
                if (wrEvent[i]) begin
                    case (offset)
                        14'h1FFE: if (!enable_q[i][4]) magicLo_q[i] <= d_from_cpu;
                        14'h1FFF: if (!enable_q[i][4]) magicHi_q[i] <= d_from_cpu;
                        14'h3FF6: begin
                            enable_q[i]   <= d_from_cpu & 8'h11;
                            overflow_q[i] <= 1'b0;
                            if (enable_q[i][4]) begin
                                magicLo_q[i] <= '0;
                                magicHi_q[i] <= '0;
                            end
                        end
                        14'h3FF7: bank_q[i] <= d_from_cpu[BANK_BITS-1:0];
                        default: ;
                    endcase
                end
                if (overflowSet[i]) overflow_q[i] <= 1'b1;
                if (push[i]) wrPtr_q[i] <= wrPtr_q[i] + PTR_ONE;
                if (pop[i])  rdPtr_q[i] <= rdPtr_q[i] + PTR_ONE;
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_ONE;
                    2'b01:   count_q[i] <= count_q[i] - CNT_ONE;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SLOTS; i++) begin
            if (push[i]) fifoMem_q[i][wrPtr_q[i]] <= {addr[0], d_from_cpu};
        end
    end

    // Round-robin scan starting at the pointer; the winner's head is what gets issued.
    always_comb begin
        found       = 1'b0;
        winner      = '0;
        scanIdx     = '0;
        notEmptyPad = 4'(notEmpty);
        for (int k = 0; k < SLOTS; k++) begin
            scanIdx = {1'b0, arbPtr_q} + 3'(k);
            if (scanIdx >= SLOTS_3) scanIdx = scanIdx - SLOTS_3;
            if (!found && notEmptyPad[scanIdx[1:0]]) begin
                found  = 1'b1;
                winner = scanIdx[1:0];
            end
        end
        nextIdx = {1'b0, winner} + 3'd1;
        if (nextIdx >= SLOTS_3) nextIdx = '0;
        headData = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (winner == 2'(i)) headData = fifoMem_q[i][rdPtr_q[i]];
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        arbPtr_d   = arbPtr_q;
        opllWr_d   = 1'b0;
        opllCh_d   = opllCh_q;
        opllA0_d   = opllA0_q;
        opllDout_d = opllDout_q;
        popValid   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    popValid   = 1'b1;
                    opllWr_d   = 1'b1;
                    opllCh_d   = winner;
                    opllA0_d   = headData[8];
                    opllDout_d = headData[7:0];
                    arbPtr_d   = nextIdx[1:0];
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_d   = opllA0_q ? WAIT_D : WAIT_A;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // Leaving as the count hits zero gives a strobe spacing of wait+2.
                if (cnt_q <= WAIT_ONE) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - WAIT_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < SLOTS; i++) begin
            pop[i] = popValid & (winner == 2'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            arbPtr_q   <= '0;
            opllWr_q   <= 1'b0;
            opllCh_q   <= '0;
            opllA0_q   <= 1'b0;
            opllDout_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            arbPtr_q   <= arbPtr_d;
            opllWr_q   <= opllWr_d;
            opllCh_q   <= opllCh_d;
            opllA0_q   <= opllA0_d;
            opllDout_q <= opllDout_d;
        end
    end

    assign opll_wr   = opllWr_q;
    assign opll_ch   = opllCh_q;
    assign opll_a0   = opllA0_q;
    assign opll_dout = opllDout_q;

    // Unselected channels drive 0xFF so the AND across channels is transparent.
    always_comb begin
        logic [7:0] chanRd;
        logic       chanSram;
        mapper_dout    = 8'hFF;
        sram_cs        = 1'b0;
        mem_addr       = '0;
        opll_io_enable = '0;
        chanRd         = 8'hFF;
        chanSram       = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            opll_io_enable[i] = enable_q[i][0];
            case (offset)
                14'h3FF6: chanRd = {notEmpty[i], overflow_q[i], 1'b0, enable_q[i][4],
                                    3'b000, enable_q[i][0]};
                14'h3FF7: chanRd = 8'(bank_q[i]);
                14'h1FFE: chanRd = sramEnable[i] ? magicLo_q[i] : 8'hFF;
                14'h1FFF: chanRd = sramEnable[i] ? magicHi_q[i] : 8'hFF;
                default:  chanRd = 8'hFF;
            endcase
            chanSram = cs[i] & sramEnable[i] & ~addr[13] & (rd | wr);
            if (cs[i]) begin
                mapper_dout = mapper_dout & chanRd;
                mem_addr    = mem_addr | (chanSram ? 25'(addr[SRAM_AW-1:0])
                                                   : 25'({bank_q[i], offset}));
            end
            sram_cs = sram_cs | chanSram;
        end
    end

    assign sram_we     = sram_cs & wr & mreq;
    assign mem_unmaped = (|cs) & (addr[15:14] != 2'b01);

endmodule

// File: tb/tb_fm_pac_multi.sv
// Directed bench for fm_pac_multi: register map, SRAM unlock, OPLL FIFO, arbitration and pacing.
module tb_fm_pac_multi;

    localparam int SLOTS     = 2;
    localparam int WAIT_ADDR = 12;
    localparam int WAIT_DATA = 84;

    logic             clk;
    logic             reset;
    logic [15:0]      addr;
    logic [7:0]       dFromCpu;
    logic [7:0]       mapperDout;
    logic [SLOTS-1:0] cs;
    logic             wr, rd, mreq;
    logic             sramCs, sramWe, memUnmaped;
    logic [24:0]      memAddr;
    logic             opllWr;
    logic [1:0]       opllCh;
    logic             opllA0;
    logic [7:0]       opllDout;
    logic [SLOTS-1:0] opllIoEnable;

    int         checks = 0;
    int         errors = 0;
    int         cycle  = 0;
    logic [10:0] stData[$];
    int          stCycle[$];
    logic [7:0]  v;

    fm_pac_multi #(
        .SLOTS(SLOTS), .BANK_BITS(2), .SRAM_AW(13), .FIFO_DEPTH(4),
        .WAIT_ADDR(WAIT_ADDR), .WAIT_DATA(WAIT_DATA)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_from_cpu(dFromCpu),
        .mapper_dout(mapperDout), .cs(cs), .wr(wr), .rd(rd), .mreq(mreq),
        .sram_cs(sramCs), .sram_we(sramWe), .mem_unmaped(memUnmaped),
        .mem_addr(memAddr), .opll_wr(opllWr), .opll_ch(opllCh), .opll_a0(opllA0),
        .opll_dout(opllDout), .opll_io_enable(opllIoEnable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Every strobe is logged as {ch, a0, data} with the cycle it was seen in.
    always @(negedge clk) begin
        if (opllWr === 1'b1) begin
            stData.push_back({opllCh, opllA0, opllDout});
            stCycle.push_back(cycle);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic [15:0] a, input logic [7:0] d);
        cs       = SLOTS'(1 << ch);
        addr     = a;
        dFromCpu = d;
        wr       = 1'b1;
        mreq     = 1'b1;
        @(negedge clk);
        wr   = 1'b0;
        mreq = 1'b0;
        cs   = '0;
        @(negedge clk);
    endtask

    task automatic readReg(input int ch, input logic [15:0] a, output logic [7:0] val);
        cs   = SLOTS'(1 << ch);
        addr = a;
        rd   = 1'b1;
        mreq = 1'b1;
        #1 val = mapperDout;
        rd   = 1'b0;
        mreq = 1'b0;
        cs   = '0;
        #1;
    endtask

    task automatic waitStrobes(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (stData.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        checkOutput(tag, 32'(stData.size()), 32'(n));
    endtask

    task automatic checkStrobe(input int idx, input logic [10:0] exp, input string tag);
        logic [10:0] got;
        got = (idx < stData.size()) ? stData[idx] : 11'h7FF;
        checkOutput(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        reset = 1'b0; addr = '0; dFromCpu = '0; cs = '0;
        wr = 1'b0; rd = 1'b0; mreq = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_opll_wr", 32'(opllWr), 32'h0);
        checkOutput("rst_opll_dout", 32'(opllDout), 32'h0);
        checkOutput("rst_io_enable", 32'(opllIoEnable), 32'h0);
        checkOutput("rst_dout_nocs", 32'(mapperDout), 32'hFF);
        readReg(0, 16'h7FF6, v);
        checkOutput("rst_status", 32'(v), 32'h00);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] enable and bank registers");
        applyStimulus(0, 16'h7FF6, 8'hFF);
        applyStimulus(0, 16'h7FF6, 8'h11);
        readReg(0, 16'h7FF6, v);
        checkOutput("enable_read", 32'(v), 32'h11);
        checkOutput("io_enable", 32'(opllIoEnable), 32'h1);
        applyStimulus(0, 16'h7FF7, 8'hFE);
        readReg(0, 16'h7FF7, v);
        checkOutput("bank_read", 32'(v), 32'h02);
        readReg(0, 16'h7123, v);
        checkOutput("other_read", 32'(v), 32'hFF);

        $display("[TB] back-to-back OPLL writes on ch1");
        applyStimulus(1, 16'h7FF4, 8'h10);
        applyStimulus(1, 16'h7FF5, 8'h55);
        waitStrobes(2, 200, "b2b_count");
        checkStrobe(0, 11'h210, "b2b_first");
        checkStrobe(1, 11'h355, "b2b_second");
        checkOutput("b2b_spacing", 32'(stCycle[1] - stCycle[0]), 32'(WAIT_ADDR + 2));
        checkOutput("hold_dout", 32'({opllCh, opllA0, opllDout}), 32'h355);

        $display("[TB] overflow while pacing");
        for (int i = 0; i < 5; i++) applyStimulus(0, 16'h7FF5, 8'(8'hA0 + i));
        readReg(0, 16'h7FF6, v);
        checkOutput("ovf_status", 32'(v), 32'hD1);
        waitStrobes(6, 1000, "ovf_count");
        checkStrobe(2, 11'h1A0, "ovf_s0");
        checkStrobe(3, 11'h1A1, "ovf_s1");
        checkStrobe(4, 11'h1A2, "ovf_s2");
        checkStrobe(5, 11'h1A3, "ovf_s3");
        checkOutput("ovf_spacing", 32'(stCycle[3] - stCycle[2]), 32'(WAIT_DATA + 2));
        repeat (100) @(negedge clk);
        checkOutput("ovf_no_fifth", 32'(stData.size()), 32'd6);
        readReg(0, 16'h7FF6, v);
        checkOutput("ovf_sticky", 32'(v), 32'h51);
        applyStimulus(0, 16'h7FF6, 8'h11);
        readReg(0, 16'h7FF6, v);
        checkOutput("ovf_cleared", 32'(v), 32'h11);

        $display("[TB] round-robin alternation");
        applyStimulus(0, 16'h7FF4, 8'h20);
        applyStimulus(1, 16'h7FF5, 8'h30);
        applyStimulus(0, 16'h7FF4, 8'h21);
        applyStimulus(1, 16'h7FF5, 8'h31);
        waitStrobes(10, 500, "rr_count");
        checkStrobe(6, 11'h020, "rr_0");
        checkStrobe(7, 11'h330, "rr_1");
        checkStrobe(8, 11'h021, "rr_2");
        checkStrobe(9, 11'h331, "rr_3");
        repeat (100) @(negedge clk);

        $display("[TB] SRAM unlock on ch1");
        applyStimulus(1, 16'h5FFE, 8'h4D);
        applyStimulus(1, 16'h5FFF, 8'h69);
        readReg(1, 16'h5FFE, v);
        checkOutput("magic_lo", 32'(v), 32'h4D);
        readReg(1, 16'h5FFF, v);
        checkOutput("magic_hi", 32'(v), 32'h69);
        cs = 2'b10; addr = 16'h5000; wr = 1'b1; mreq = 1'b1;
        #1;
        checkOutput("sram_we", 32'(sramWe), 32'h1);
        checkOutput("sram_addr", 32'(memAddr), 32'h1000);
        checkOutput("mapped", 32'(memUnmaped), 32'h0);
        @(negedge clk);
        wr = 1'b0; mreq = 1'b0; rd = 1'b1; addr = 16'h6000;
        #1;
        checkOutput("rom_upper_cs", 32'(sramCs), 32'h0);
        checkOutput("rom_upper_addr", 32'(memAddr), 32'h2000);
        addr = 16'h8000;
        #1 checkOutput("unmapped_hi", 32'(memUnmaped), 32'h1);
        addr = 16'h3FFF;
        #1 checkOutput("unmapped_lo", 32'(memUnmaped), 32'h1);
        addr = 16'h7FFF;
        #1 checkOutput("mapped_top", 32'(memUnmaped), 32'h0);
        rd = 1'b0; cs = '0;
        @(negedge clk);
        applyStimulus(1, 16'h7FF6, 8'h10);
        readReg(1, 16'h5FFE, v);
        checkOutput("magic_kept", 32'(v), 32'h4D);
        applyStimulus(1, 16'h7FF6, 8'h10);
        checkOutput("io_enable_ch1", 32'(opllIoEnable), 32'h1);
        readReg(1, 16'h7FF6, v);
        checkOutput("ch1_status", 32'(v), 32'h10);
        applyStimulus(1, 16'h7FF7, 8'h03);
        applyStimulus(1, 16'h5FFE, 8'h4D);
        applyStimulus(1, 16'h5FFF, 8'h69);
        cs = 2'b10; addr = 16'h5000; rd = 1'b1;
        #1;
        checkOutput("locked_cs", 32'(sramCs), 32'h0);
        checkOutput("locked_addr", 32'(memAddr), 32'hD000);
        rd = 1'b0; cs = '0;
        readReg(1, 16'h5FFE, v);
        checkOutput("locked_magic", 32'(v), 32'hFF);
        @(negedge clk);

        $display("[TB] held write strobe");
        cs = 2'b01; addr = 16'h7FF4; dFromCpu = 8'h77; wr = 1'b1; mreq = 1'b1;
        repeat (10) @(negedge clk);
        wr = 1'b0; mreq = 1'b0; cs = '0;
        waitStrobes(11, 100, "held_count");
        checkStrobe(10, 11'h077, "held_data");
        repeat (50) @(negedge clk);
        checkOutput("held_single", 32'(stData.size()), 32'd11);

        $display("[TB] reset during WAIT");
        applyStimulus(0, 16'h7FF5, 8'h88);
        applyStimulus(0, 16'h7FF5, 8'h99);
        waitStrobes(12, 50, "rw_count");
        checkStrobe(11, 11'h188, "rw_data");
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rw_opll_wr", 32'(opllWr), 32'h0);
        checkOutput("rw_dout", 32'(opllDout), 32'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (150) @(negedge clk);
        checkOutput("rw_no_strobe", 32'(stData.size()), 32'd12);
        readReg(0, 16'h7FF6, v);
        checkOutput("rw_fifo_empty", 32'(v), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
